// File: rtl/stream_pkg.sv
// Shared stream definitions: FSM state encoding and default datapath widths
// for the burst generator and future stream sinks/checkers.
package stream_pkg;

   localparam int unsigned STREAM_DATA_WIDTH = 32;
   localparam int unsigned STREAM_LEN_WIDTH  = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } stream_state_t;

endpackage

// File: rtl/stream_burst_gen.sv
// Valid/ready burst transmitter: emits cmd_len words start, start+step, ...
// Optional out_last port enabled by defining STREAM_BURST_GEN_LAST_EN.
module stream_burst_gen
   import stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = STREAM_DATA_WIDTH,
   parameter int unsigned LEN_WIDTH  = STREAM_LEN_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [DATA_WIDTH-1:0] cmd_start,
   input  logic [DATA_WIDTH-1:0] cmd_step,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
`ifdef STREAM_BURST_GEN_LAST_EN
   output logic                  out_last,
`endif
   output logic                  busy,
   output logic                  done
);

   stream_state_t         r_state;
   logic [DATA_WIDTH-1:0] r_data;
   logic [DATA_WIDTH-1:0] r_step;
   logic [LEN_WIDTH-1:0]  r_remaining;
   logic                  r_out_valid;
   logic                  r_busy;
   logic                  r_done;
   logic                  w_last_word;

   assign w_last_word = (r_remaining == LEN_WIDTH'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_data      <= '0;
         r_step      <= '0;
         r_remaining <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_busy <= 1'b1;
                  if (cmd_len != '0) begin
                     r_data      <= cmd_start;
                     r_step      <= cmd_step;
                     r_remaining <= cmd_len;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_SEND;
                  end else begin
                     // zero-length burst: no words, straight to the done pulse
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_SEND: begin
               if (out_ready) begin
                  r_data      <= r_data + r_step;
                  r_remaining <= r_remaining - LEN_WIDTH'(1);
                  if (w_last_word) begin
                     r_out_valid <= 1'b0;
                     r_done      <= 1'b1;
                     r_state     <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   // cmd_ready is forced low while rst is held so no command slips in during reset
   assign cmd_ready = (r_state == ST_IDLE) && !rst;
   assign out_valid = r_out_valid;
   assign out_data  = r_data;
   assign busy      = r_busy;
   assign done      = r_done;

`ifdef STREAM_BURST_GEN_LAST_EN
   assign out_last = (r_state == ST_SEND) && w_last_word;
`endif

endmodule

// File: tb/tb_stream_burst_gen.sv
// Scoreboard bench for stream_burst_gen; out_last is checked when
// STREAM_BURST_GEN_LAST_EN is defined.
module tb_stream_burst_gen;
   import stream_pkg::*;

   localparam int unsigned DW = STREAM_DATA_WIDTH;
   localparam int unsigned LW = STREAM_LEN_WIDTH;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] cmd_start = '0;
   logic [DW-1:0] cmd_step = '0;
   logic [LW-1:0] cmd_len = '0;
   logic          cmd_ready, out_valid, busy, done;
   logic [DW-1:0] out_data;
`ifdef STREAM_BURST_GEN_LAST_EN
   logic          out_last;
`endif

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   hs_cnt = 0;
   int   done_cnt = 0;
   int   valid_cnt = 0;
   int   first_hs = -1;
   int   last_hs = -1;
   int   done_vis = -1;
   logic          prev_stall = 1'b0;
   logic          prev_rst = 1'b1;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   stream_burst_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_start (cmd_start),
      .cmd_step  (cmd_step),
      .cmd_len   (cmd_len),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
`ifdef STREAM_BURST_GEN_LAST_EN
      .out_last  (out_last),
`endif
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor: sampled mid-cycle; a handshake seen here completes at edge cyc+1.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst && !prev_rst && prev_stall) begin
         check("stall_valid", 64'(out_valid), 64'd1);
         check("stall_data", 64'(out_data), 64'(prev_data));
`ifdef STREAM_BURST_GEN_LAST_EN
         check("stall_last", 64'(out_last), 64'(prev_last));
`endif
      end
      if (out_valid) begin
         valid_cnt++;
         check("ready_in_send", 64'(cmd_ready), 64'd0);
      end
      if (done) begin
         done_cnt++;
         done_vis = cyc;
      end
      if (out_valid && out_ready && !rst) begin
         hs_cnt++;
         if (first_hs < 0) first_hs = cyc + 1;
         last_hs = cyc + 1;
         if (sb.size() == 0) begin
            check("unexpected_word", 64'(out_data), 64'hDEAD_0000_0000_0000);
         end else begin
            e = sb.pop_front();
            check("data", 64'(out_data), 64'(e.data));
`ifdef STREAM_BURST_GEN_LAST_EN
            check("last", 64'(out_last), 64'(e.last));
`endif
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
`ifdef STREAM_BURST_GEN_LAST_EN
      prev_last  = out_last;
`endif
      prev_rst   = rst;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pushes the expected words, offers the command, returns the accepting edge index.
   task automatic send_cmd(input logic [DW-1:0] s, input logic [DW-1:0] st,
                           input logic [LW-1:0] l, output int acc);
      logic [DW-1:0] d;
      exp_t          e;
      d = s;
      for (int i = 0; i < int'(l); i++) begin
         e.data = d;
         e.last = (i == int'(l) - 1);
         sb.push_back(e);
         d = d + st;
      end
      cmd_valid = 1'b1;
      cmd_start = s;
      cmd_step  = st;
      cmd_len   = l;
      acc = -1;
      for (int t = 0; t < 400 && acc < 0; t++) begin
         @(negedge clk);
         if (cmd_ready) begin
            @(posedge clk);
            #1;
            acc = cyc;
         end
      end
      if (acc < 0) begin
         check("cmd_accept_timeout", 64'd0, 64'd1);
         tick();
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int prev);
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 300 && !seen; t++) begin
         @(negedge clk);
         #1;
         if (done_cnt > prev) seen = 1'b1;
      end
      if (!seen) check("done_timeout", 64'd0, 64'd1);
      tick();
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int acc, acc2, d0, h0, v0;
      logic [5:0] pat_bp;
      logic [6:0] pat_last;

      // Reset state
      repeat (3) tick();
      @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rel_cmd_ready", 64'(cmd_ready), 64'd1);
      tick();

      // Single burst, full throughput
      out_ready = 1'b1;
      first_hs = -1; d0 = done_cnt; h0 = hs_cnt;
      send_cmd(32'h10, 32'd1, 16'd4, acc);
      @(negedge clk);
      check("t1_valid_latency", 64'(out_valid), 64'd1);
      check("t1_busy", 64'(busy), 64'd1);
      wait_done(d0);
      repeat (2) tick();
      check("t1_hs_count", 64'(hs_cnt - h0), 64'd4);
      check("t1_first_hs", 64'(first_hs), 64'(acc + 1));
      check("t1_last_hs", 64'(last_hs), 64'(acc + 4));
      check("t1_done_cycle", 64'(done_vis), 64'(acc + 4));
      check("t1_done_once", 64'(done_cnt - d0), 64'd1);

      // Backpressure 1,0,0,1,0,1
      pat_bp = 6'b101001;
      d0 = done_cnt; h0 = hs_cnt;
      send_cmd(32'hA0, 32'd4, 16'd3, acc);
      for (int i = 0; i < 6; i++) begin
         out_ready = pat_bp[i];
         tick();
      end
      out_ready = 1'b1;
      wait_done(d0);
      check("t2_hs_count", 64'(hs_cnt - h0), 64'd3);
      check("t2_last_hs", 64'(last_hs), 64'(acc + 6));
      check("t2_sb_empty", 64'(sb.size()), 64'd0);

      // Wrap-around then zero length
      d0 = done_cnt; h0 = hs_cnt;
      send_cmd(32'hFFFF_FFFE, 32'd1, 16'd3, acc);
      wait_done(d0);
      check("t3_hs_count", 64'(hs_cnt - h0), 64'd3);
      d0 = done_cnt; v0 = valid_cnt;
      send_cmd(32'h55, 32'd7, 16'd0, acc);
      wait_done(d0);
      repeat (2) tick();
      check("t3_len0_no_valid", 64'(valid_cnt - v0), 64'd0);
      check("t3_len0_done_cycle", 64'(done_vis), 64'(acc));
      check("t3_len0_done_once", 64'(done_cnt - d0), 64'd1);

      // Command held while busy
      d0 = done_cnt;
      send_cmd(32'h200, 32'd3, 16'd5, acc);
      @(negedge clk);
      check("t4_busy", 64'(busy), 64'd1);
      check("t4_ready_low", 64'(cmd_ready), 64'd0);
      send_cmd(32'h300, 32'd1, 16'd2, acc2);
      check("t4_gap_from_last", 64'(acc2), 64'(last_hs + 2));
      check("t4_gap_from_accept", 64'(acc2), 64'(acc + 7));
      d0 = done_cnt;
      wait_done(d0);
      check("t4_sb_empty", 64'(sb.size()), 64'd0);

      // Reset after 2 of 6 words
      d0 = done_cnt; h0 = hs_cnt;
      send_cmd(32'h100, 32'd1, 16'd6, acc);
      tick();
      tick();
      rst = 1'b1;
      out_ready = 1'b0;
      tick();
      @(negedge clk);
      check("t5_valid_dropped", 64'(out_valid), 64'd0);
      check("t5_ready_in_rst", 64'(cmd_ready), 64'd0);
      check("t5_busy_cleared", 64'(busy), 64'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("t5_ready_after_rel", 64'(cmd_ready), 64'd1);
      check("t5_hs_count", 64'(hs_cnt - h0), 64'd2);
      check("t5_discarded", 64'(sb.size()), 64'd4);
      sb.delete();
      tick();
      check("t5_no_done", 64'(done_cnt - d0), 64'd0);
      out_ready = 1'b1;
      h0 = hs_cnt;
      send_cmd(32'h0, 32'd2, 16'd2, acc);
      wait_done(d0);
      check("t5_new_burst_hs", 64'(hs_cnt - h0), 64'd2);

      // Final word stalled 3 cycles
      pat_last = 7'b1000111;
      d0 = done_cnt; h0 = hs_cnt;
      send_cmd(32'h40, 32'd1, 16'd4, acc);
      for (int i = 0; i < 7; i++) begin
         out_ready = pat_last[i];
         tick();
      end
      out_ready = 1'b1;
      wait_done(d0);
      check("t6_hs_count", 64'(hs_cnt - h0), 64'd4);
      check("t6_last_hs", 64'(last_hs), 64'(acc + 7));

      // Random start/step with out_ready toggling every cycle
      d0 = done_cnt; h0 = hs_cnt;
      send_cmd(DW'($urandom), DW'($urandom), 16'd20, acc);
      for (int i = 0; i < 60 && done_cnt == d0; i++) begin
         out_ready = ~out_ready;
         tick();
      end
      out_ready = 1'b1;
      wait_done(d0);
      check("t7_hs_count", 64'(hs_cnt - h0), 64'd20);
      check("t7_sb_empty", 64'(sb.size()), 64'd0);

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
